// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO stack: default sizes, the
// per-cycle operation encoding and the occupancy-count width helper.
package lifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // One action is selected per cycle from (push, pop, current state).
    typedef enum logic [2:0] {
        OP_IDLE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_XCHG = 3'd3,
        OP_PASS = 3'd4,
        OP_OVF  = 3'd5,
        OP_UNF  = 3'd6
    } op_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// Storage array for the LIFO stack: DEPTH x DATA_W registers with one
// synchronous write port and one combinational read port. Not reset.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: data only, so no reset on the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with registered pop data, same-cycle exchange and
// pass-through, registered flags derived from the next count, and
// overflow/underflow reporting.
// Optional build macro LIFO_ERR_STICKY_EN: overflow/underflow stay set until
// reset instead of pulsing for one cycle.
module lifo_stack_param
    import lifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             data_in,
    output logic [DATA_W-1:0]             data_out,
    output logic                          out_valid,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    op_t               op;
    logic [CNT_W-1:0]  count_nxt;
    logic [AW-1:0]     idx_top;
    logic [AW-1:0]     idx_free;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_rdata;

    // Top-of-stack entry and the first free slot; only the low bits index
    // the array, the count itself never wraps.
    assign idx_top  = AW'(count - CNT_W'(1));
    assign idx_free = AW'(count);

    // Decode the cycle's single action from the requests and registered flags.
    always_comb begin
        op = OP_IDLE;
        if (push && pop) begin
            op = empty ? OP_PASS : OP_XCHG;
        end else if (push) begin
            op = full ? OP_OVF : OP_PUSH;
        end else if (pop) begin
            op = empty ? OP_UNF : OP_POP;
        end
    end

    // Next occupancy, memory write port steering.
    always_comb begin
        count_nxt = count;
        mem_we    = 1'b0;
        mem_waddr = idx_free;
        case (op)
            OP_PUSH: begin
                count_nxt = count + CNT_W'(1);
                mem_we    = 1'b1;
            end
            OP_POP: begin
                count_nxt = count - CNT_W'(1);
            end
            OP_XCHG: begin
                mem_we    = 1'b1;
                mem_waddr = idx_top;
            end
            default: ;
        endcase
    end

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data_in),
        .raddr (idx_top),
        .rdata (mem_rdata)
    );

    // Count and flags register together so flags always match count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CNT_W'(DEPTH));
            almost_full <= (count_nxt >= CNT_W'(AFULL_TH));
        end
    end

    // Read result: exchange reads the old top before it is overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (op == OP_POP) || (op == OP_XCHG) || (op == OP_PASS);
            if ((op == OP_POP) || (op == OP_XCHG)) begin
                data_out <= mem_rdata;
            end else if (op == OP_PASS) begin
                data_out <= data_in;
            end
        end
    end

    // Error reporting: pulse per offending request, or latched until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef LIFO_ERR_STICKY_EN
            overflow  <= overflow  | (op == OP_OVF);
            underflow <= underflow | (op == OP_UNF);
`else
            overflow  <= (op == OP_OVF);
            underflow <= (op == OP_UNF);
`endif
        end
    end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed self-checking bench for lifo_stack_param (DATA_W=8, DEPTH=8).
module tb_lifo_stack_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       out_valid;
    logic [3:0] count;
    logic       empty, full, almost_full, overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;

`ifdef LIFO_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    lifo_stack_param #(
        .DATA_W   (8),
        .DEPTH    (8),
        .AFULL_TH (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic q, input logic [7:0] d);
        push    = p;
        pop     = q;
        data_in = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_afull"}, almost_full, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_unf"}, underflow, 0);
        check({tag, "_vld"}, out_valid, 0);
        check({tag, "_dout"}, data_out, 0);
    endtask

    initial begin
        logic [7:0] w;
        // Reset state
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;

        // Fill to full
        for (int i = 0; i < 8; i++) begin
            w = 8'((i + 1) * 8'h11);
            drive(1'b1, 1'b0, w);
            step();
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1 >= 7) ? 1 : 0);
            check("fill_full", full, (i + 1 == 8) ? 1 : 0);
            check("fill_empty", empty, 0);
        end
        drive(1'b1, 1'b0, 8'h99);
        step();
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_vld", out_valid, 0);
        drive(1'b0, 1'b0, 8'h00);
        step();
        check("ovf_after", overflow, STICKY);

        // Drain in reverse order
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            w = 8'((8 - i) * 8'h11);
            check("pop_data", data_out, w);
            check("pop_vld", out_valid, 1);
            check("pop_count", count, 7 - i);
        end
        check("drain_empty", empty, 1);
        drive(1'b0, 1'b1, 8'h00);
        step();
        check("unf_pulse", underflow, 1);
        check("unf_vld", out_valid, 0);
        check("unf_hold", data_out, 8'h11);
        check("unf_count", count, 0);
        drive(1'b0, 1'b0, 8'h00);
        step();
        check("unf_after", underflow, STICKY);
        check("idle_vld", out_valid, 0);

        // Exchange
        do_reset();
        drive(1'b1, 1'b0, 8'hA1); step();
        drive(1'b1, 1'b0, 8'hA2); step();
        drive(1'b1, 1'b1, 8'hB0); step();
        check("xchg_data", data_out, 8'hA2);
        check("xchg_vld", out_valid, 1);
        check("xchg_count", count, 2);
        check("xchg_ovf", overflow, 0);
        drive(1'b0, 1'b1, 8'h00); step();
        check("xpop1_data", data_out, 8'hB0);
        check("xpop1_count", count, 1);
        drive(1'b0, 1'b1, 8'h00); step();
        check("xpop2_data", data_out, 8'hA1);
        check("xpop2_count", count, 0);
        check("xpop2_empty", empty, 1);

        // Pass-through on empty
        drive(1'b1, 1'b1, 8'h5C); step();
        check("pass_data", data_out, 8'h5C);
        check("pass_vld", out_valid, 1);
        check("pass_count", count, 0);
        check("pass_empty", empty, 1);
        check("pass_unf", underflow, 0);

        // Asynchronous reset mid-cycle at count=5
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'h30 + i));
            step();
        end
        check("pre_arst_count", count, 5);
        drive(1'b0, 1'b0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("arst");
        #2;
        reset = 1'b0;
        drive(1'b0, 1'b1, 8'h00);
        step();
        check("arst_pop_unf", underflow, 1);
        check("arst_pop_vld", out_valid, 0);
        check("arst_pop_count", count, 0);

        // Overflow persistence across normal pops
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'((i + 1) * 8'h11));
            step();
        end
        drive(1'b1, 1'b0, 8'hEE); step();
        check("stk_ovf", overflow, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check("stk_pop_data", data_out, 8'((8 - i) * 8'h11));
            check("stk_ovf_hold", overflow, STICKY);
            check("stk_unf", underflow, 0);
        end
        do_reset();
        check("stk_clear", overflow, 0);
        check("stk_clear_cnt", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lifo_stack_param.md
# lifo_stack_param

Parametrised last-in/first-out buffer: configurable data width and depth, registered pop data with a valid strobe, and a same-cycle push+pop exchange. Flags (empty/full/almost_full) and occupancy count update on the same edge, with no lag. Overflow and underflow are reported as error flags. The block is the general-purpose stack for datapath blocks that need nested or return-order buffering, and replaces the fixed 8×8 stack.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2)
- AFULL_TH, DEPTH-1, almost_full asserts when count ≥ AFULL_TH (legal range 1..DEPTH)
- CNT_W, $clog2(DEPTH+1), count width (localparam, not overridable)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- push  input  1  write request
- pop  input  1  read request
- data_in  input  DATA_W  write data, sampled with push
- data_out  output  DATA_W  registered pop/exchange result
- out_valid  output  1  one-cycle strobe, data_out updated this cycle
- count  output  CNT_W  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count ≥ AFULL_TH
- overflow  output  1  push dropped because stack was full
- underflow  output  1  pop ignored because stack was empty

## Operation
- Reset values: count=0, data_out=0, out_valid=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0. Storage array is not reset.
- Each cycle, exactly one action is selected from (push, pop, state):
  - push only, not full: mem[count] ← data_in; count+1.
  - push only, full: write dropped; count unchanged; overflow asserted.
  - pop only, not empty: data_out ← mem[count-1]; out_valid=1; count-1.
  - pop only, empty: data_out holds; out_valid=0; underflow asserted.
  - push+pop, not empty (exchange): data_out ← mem[count-1]; mem[count-1] ← data_in; count unchanged; out_valid=1. Legal when full; no overflow.
  - push+pop, empty (pass-through): data_out ← data_in; out_valid=1; count stays 0; no underflow.
  - neither: all state holds; out_valid=0.
- Flags are computed from the next count and registered, so on every edge they are consistent with count.
- Wrap-around is impossible. count never exceeds DEPTH and never goes below 0.
- Pointer arithmetic is done at CNT_W bits. Memory index uses the low $clog2(DEPTH) bits.

## Timing
- Pop/exchange latency: 1 cycle. The request is sampled at edge N; data_out and out_valid are valid after edge N; out_valid drops after edge N+1 unless another read occurs.
- Push is visible to a pop issued on the next cycle: push at N, pop at N+1 returns that word after edge N+1.
- overflow/underflow: one-cycle pulse in the cycle after the offending request (default build).
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). Stored data is logically discarded. The first cycle after deassertion behaves as an empty stack.

## Configuration
- LIFO_ERR_STICKY_EN defined: overflow and underflow are sticky. Once set, each stays 1 until reset. Normal operation continues unaffected.
- LIFO_ERR_STICKY_EN undefined: both are single-cycle pulses per offending request.

## Structure
- Shared package lifo_pkg holds:
  - default DATA_W/DEPTH constants
  - the op encoding typedef (OP_IDLE, OP_PUSH, OP_POP, OP_XCHG, OP_PASS, OP_OVF, OP_UNF)
  - the count-width function
- One sub-module: lifo_mem, a DEPTH×DATA_W register array with one write port and one combinational read port.
- The control, flags and count live in the top level.

## Test plan
- Reset, then 8 pushes of 0x11..0x88 (DEPTH=8) → count=8, full=1, almost_full=1 from count 7, empty=0; 9th push gives overflow pulse and count stays 8.
- 8 pops from full → data_out 0x88,0x11 order reversed, each with out_valid, one cycle later; the 9th pop gives underflow=1, out_valid=0, data_out holds 0x11.
- Push 0xA1, 0xA2, then push+pop with 0xB0 → data_out=0xA2, count=2; a following pop returns 0xB0, then 0xA1.
- Push+pop with 0x5C on empty → data_out=0x5C, out_valid=1, count=0, empty=1, underflow=0.
- Assert reset asynchronously mid-stream at count=5 → all outputs at reset values before the next edge; a pop after release gives underflow.
- With LIFO_ERR_STICKY_EN: force an overflow then 3 normal pops → overflow remains 1 until reset; without the macro it is a 1-cycle pulse.
